// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the hazard control unit
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } hcu_state_t;

   localparam int REG_ZERO  = 0;
   localparam int MAX_REG_W = 8;

   // Callers zero-extend their register indices to MAX_REG_W bits.
   function automatic logic src_match(input logic [MAX_REG_W-1:0] idx,
                                      input logic                 used,
                                      input logic [MAX_REG_W-1:0] dest);
      return used && (idx == dest);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// A clear with enable also high restarts the count at 1 instead of 0.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr)
         count <= W'(en);
      else if (en && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - stall/bubble/flush sequencing for the scalar pipeline
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int REG_W       = 4,
   parameter int LOAD_STALLS = 1,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] r2_id,
   input  logic [REG_W-1:0] r3_id,
   input  logic             r2_used_id,
   input  logic             r3_used_id,
   input  logic [REG_W-1:0] dest_ex,
   input  logic             ex_wr_en,
   input  logic             ex_is_load,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             branch_taken_ex,
   output logic             stall_front,
   output logic             stall_back,
   output logic             bubble_ex,
   output logic             bubble_wb,
   output logic             flush_if_id,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [1:0]       state_dbg
);

   localparam int              TO_W    = 8;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

   hcu_state_t       state, state_next;
   logic [2:0]       lcnt, lcnt_next;
   logic [TO_W-1:0]  tcnt;
   logic [CNT_W-1:0] scnt;
   logic             timeout_flag, timeout_set;
   logic             tcnt_clr, tcnt_en, run_eval;
   logic             hazard, memwait;
   logic             sf, sb, bex, bwb, fl;

   assign memwait = mem_req & ~mem_ready;
   assign hazard  = ex_is_load & ex_wr_en & (dest_ex != REG_W'(REG_ZERO)) &
                    (src_match(MAX_REG_W'(r2_id), r2_used_id, MAX_REG_W'(dest_ex)) |
                     src_match(MAX_REG_W'(r3_id), r3_used_id, MAX_REG_W'(dest_ex)));

   always_comb begin
      state_next  = state;
      lcnt_next   = lcnt;
      sf          = 1'b0;
      sb          = 1'b0;
      bex         = 1'b0;
      bwb         = 1'b0;
      fl          = 1'b0;
      timeout_set = 1'b0;
      tcnt_clr    = 1'b1;
      tcnt_en     = 1'b0;
      run_eval    = 1'b0;

      case (state)
         LOAD_STALL: begin
            if (memwait) begin
               run_eval = 1'b1;
            end else begin
               sf  = 1'b1;
               bex = 1'b1;
               if (lcnt <= 3'd1)
                  state_next = RUN;
               else
                  lcnt_next = lcnt - 3'd1;
            end
         end
         MEM_WAIT: begin
            if (memwait) begin
               sf       = 1'b1;
               sb       = 1'b1;
               bwb      = 1'b1;
               tcnt_clr = 1'b0;
               tcnt_en  = 1'b1;
               if (tcnt >= TO_LAST) begin
                  timeout_set = 1'b1;
                  state_next  = RUN;
               end
            end else begin
               run_eval = 1'b1;
            end
         end
         default: run_eval = 1'b1;
      endcase

      // RUN decisions, also used for the release cycle of MEM_WAIT.
      if (run_eval) begin
         state_next = RUN;
         if (memwait) begin
            sf         = 1'b1;
            sb         = 1'b1;
            bwb        = 1'b1;
            tcnt_en    = 1'b1;
            state_next = MEM_WAIT;
         end else if (branch_taken_ex) begin
            fl  = 1'b1;
            bex = 1'b1;
         end else if (hazard) begin
            sf  = 1'b1;
            bex = 1'b1;
            if (LOAD_STALLS > 1) begin
               state_next = LOAD_STALL;
               lcnt_next  = 3'(LOAD_STALLS - 1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         lcnt         <= '0;
         timeout_flag <= 1'b0;
      end else begin
         state <= state_next;
         lcnt  <= lcnt_next;
         if (timeout_set)
            timeout_flag <= 1'b1;
      end
   end

   sat_counter #(.W(TO_W)) u_timeout_cnt (
      .clk   (clk),
      .clr   (tcnt_clr | rst),
      .en    (tcnt_en & ~rst),
      .count (tcnt)
   );

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr   (rst),
      .en    (stall_front),
      .count (scnt)
   );

   assign stall_front = sf  & ~rst;
   assign stall_back  = sb  & ~rst;
   assign bubble_ex   = bex & ~rst;
   assign bubble_wb   = bwb & ~rst;
   assign flush_if_id = fl  & ~rst;
   assign mem_timeout = timeout_flag & ~rst;
   assign stall_count = rst ? '0 : scnt;
   assign state_dbg   = rst ? 2'd0 : state;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - scoreboard bench for hazard_control_unit
module tb_hazard_control_unit;

   typedef struct packed {
      logic [3:0] r2;
      logic       u2;
      logic [3:0] r3;
      logic       u3;
      logic [3:0] dest;
      logic       wr;
      logic       ld;
      logic       req;
      logic       rdy;
      logic       br;
   } stim_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] r2_id, r3_id, dest_ex;
   logic r2_used_id, r3_used_id, ex_wr_en, ex_is_load, mem_req, mem_ready, branch_taken_ex;

   logic sf_a, sb_a, bex_a, bwb_a, fl_a, to_a;
   logic [1:0]  st_a;
   logic [31:0] cnt_a;
   logic sf_b, sb_b, bex_b, bwb_b, fl_b, to_b;
   logic [1:0]  st_b;
   logic [3:0]  cnt_b;
   logic [7:0]  obs_a, obs_b;

   int checks = 0;
   int failures = 0;
   logic [7:0] sb_q[$];
   int         cnt_q[$];

   assign obs_a = {sf_a, sb_a, bex_a, bwb_a, fl_a, to_a, st_a};
   assign obs_b = {sf_b, sb_b, bex_b, bwb_b, fl_b, to_b, st_b};

   always #5 clk = ~clk;

   hazard_control_unit #(.REG_W(4), .LOAD_STALLS(1), .MEM_TIMEOUT(255), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .r2_id(r2_id), .r3_id(r3_id), .r2_used_id(r2_used_id),
      .r3_used_id(r3_used_id), .dest_ex(dest_ex), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
      .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken_ex(branch_taken_ex),
      .stall_front(sf_a), .stall_back(sb_a), .bubble_ex(bex_a), .bubble_wb(bwb_a),
      .flush_if_id(fl_a), .mem_timeout(to_a), .stall_count(cnt_a), .state_dbg(st_a));

   hazard_control_unit #(.REG_W(4), .LOAD_STALLS(3), .MEM_TIMEOUT(8), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .r2_id(r2_id), .r3_id(r3_id), .r2_used_id(r2_used_id),
      .r3_used_id(r3_used_id), .dest_ex(dest_ex), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
      .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken_ex(branch_taken_ex),
      .stall_front(sf_b), .stall_back(sb_b), .bubble_ex(bex_b), .bubble_wb(bwb_b),
      .flush_if_id(fl_b), .mem_timeout(to_b), .stall_count(cnt_b), .state_dbg(st_b));

   function automatic stim_t mk(input logic [3:0] r2, input logic u2, input logic [3:0] r3,
                                input logic u3, input logic [3:0] dest, input logic wr,
                                input logic ld, input logic req, input logic rdy, input logic br);
      stim_t s;
      s = '{r2: r2, u2: u2, r3: r3, u3: u3, dest: dest, wr: wr, ld: ld, req: req, rdy: rdy, br: br};
      return s;
   endfunction

   function automatic logic [7:0] ex(input logic f_sf, input logic f_sb, input logic f_bex,
                                     input logic f_bwb, input logic f_fl, input logic f_to,
                                     input logic [1:0] f_st);
      return {f_sf, f_sb, f_bex, f_bwb, f_fl, f_to, f_st};
   endfunction

   task automatic drive(input stim_t s);
      r2_id = s.r2;  r2_used_id = s.u2;
      r3_id = s.r3;  r3_used_id = s.u3;
      dest_ex = s.dest;  ex_wr_en = s.wr;  ex_is_load = s.ld;
      mem_req = s.req;   mem_ready = s.rdy; branch_taken_ex = s.br;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive('0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   localparam stim_t IDLE = '0;
   localparam stim_t HAZ  = '{r2: 4'd0, u2: 1'b0, r3: 4'd5, u3: 1'b1, dest: 4'd5,
                              wr: 1'b1, ld: 1'b1, req: 1'b0, rdy: 1'b0, br: 1'b0};

   task automatic test_reset();
      logic [7:0] e;
      rst = 1'b1;
      drive(mk(4'd5, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
      for (int i = 0; i < 2; i++) begin
         sb_q.push_back(8'h00);
         sb_q.push_back(8'h00);
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if (obs_a !== e) begin failures++; $display("FAIL reset_a cyc%0d got=%b exp=%b", i, obs_a, e); end
         e = sb_q.pop_front();
         checks++;
         if (obs_b !== e) begin failures++; $display("FAIL reset_b cyc%0d got=%b exp=%b", i, obs_b, e); end
         checks++;
         if (cnt_a !== 32'd0 || cnt_b !== 4'd0) begin
            failures++; $display("FAIL reset_cnt cyc%0d got=%0d/%0d exp=0/0", i, cnt_a, cnt_b);
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
      drive(IDLE);
   endtask

   task automatic test_load_use();
      stim_t s[$];
      logic [7:0] ev[$];
      logic [7:0] e;
      do_reset();
      s = '{HAZ, IDLE};
      ev = '{ex(1, 0, 1, 0, 0, 0, 2'd0), ex(0, 0, 0, 0, 0, 0, 2'd0)};
      foreach (s[i]) begin
         drive(s[i]);
         sb_q.push_back(ev[i]);
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if (obs_a !== e) begin failures++; $display("FAIL load_use cyc%0d got=%b exp=%b", i, obs_a, e); end
         @(posedge clk); #1;
      end
      checks++;
      if (cnt_a !== 32'd1) begin failures++; $display("FAIL load_use_cnt got=%0d exp=1", cnt_a); end
   endtask

   task automatic test_no_hazard();
      stim_t s[$];
      logic [7:0] e;
      do_reset();
      s = '{mk(4'd3, 1'b1, 4'd5, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0),
            mk(4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0),
            mk(4'd5, 1'b1, 4'd0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0),
            mk(4'd5, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
      foreach (s[i]) begin
         drive(s[i]);
         sb_q.push_back(8'h00);
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if (obs_a !== e) begin failures++; $display("FAIL no_hazard cyc%0d got=%b exp=%b", i, obs_a, e); end
         @(posedge clk); #1;
      end
      checks++;
      if (cnt_a !== 32'd0) begin failures++; $display("FAIL no_hazard_cnt got=%0d exp=0", cnt_a); end
   endtask

   task automatic test_multi_stall();
      stim_t s[$];
      logic [7:0] ev[$];
      logic [7:0] e;
      do_reset();
      s = '{HAZ, HAZ, HAZ, IDLE};
      ev = '{ex(1, 0, 1, 0, 0, 0, 2'd0), ex(1, 0, 1, 0, 0, 0, 2'd1),
             ex(1, 0, 1, 0, 0, 0, 2'd1), ex(0, 0, 0, 0, 0, 0, 2'd0)};
      foreach (s[i]) begin
         drive(s[i]);
         sb_q.push_back(ev[i]);
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if (obs_b !== e) begin failures++; $display("FAIL multi_stall cyc%0d got=%b exp=%b", i, obs_b, e); end
         @(posedge clk); #1;
      end
      checks++;
      if (cnt_b !== 4'd3) begin failures++; $display("FAIL multi_stall_cnt got=%0d exp=3", cnt_b); end
   endtask

   task automatic test_stall_override();
      stim_t s[$];
      stim_t w, r;
      logic [7:0] ev[$];
      logic [7:0] e;
      do_reset();
      w = HAZ; w.req = 1'b1;
      r = IDLE; r.req = 1'b1; r.rdy = 1'b1;
      s = '{HAZ, w, w, r, IDLE};
      ev = '{ex(1, 0, 1, 0, 0, 0, 2'd0), ex(1, 1, 0, 1, 0, 0, 2'd1), ex(1, 1, 0, 1, 0, 0, 2'd2),
             ex(0, 0, 0, 0, 0, 0, 2'd2), ex(0, 0, 0, 0, 0, 0, 2'd0)};
      foreach (s[i]) begin
         drive(s[i]);
         sb_q.push_back(ev[i]);
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if (obs_b !== e) begin failures++; $display("FAIL stall_override cyc%0d got=%b exp=%b", i, obs_b, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_wait();
      stim_t w, r;
      logic [7:0] e;
      do_reset();
      w = IDLE; w.req = 1'b1;
      r = w;    r.rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(i < 4 ? w : (i == 4 ? r : IDLE));
         sb_q.push_back(i < 4 ? ex(1, 1, 0, 1, 0, 0, (i == 0) ? 2'd0 : 2'd2)
                              : ex(0, 0, 0, 0, 0, 0, (i == 4) ? 2'd2 : 2'd0));
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if (obs_a !== e) begin failures++; $display("FAIL mem_wait cyc%0d got=%b exp=%b", i, obs_a, e); end
         @(posedge clk); #1;
      end
      checks++;
      if (cnt_a !== 32'd4) begin failures++; $display("FAIL mem_wait_cnt got=%0d exp=4", cnt_a); end
   endtask

   task automatic test_branch();
      stim_t s[$];
      stim_t bh, bw, br;
      logic [7:0] ev[$];
      logic [7:0] e;
      do_reset();
      bh = HAZ;  bh.br = 1'b1;
      bw = IDLE; bw.br = 1'b1; bw.req = 1'b1;
      br = bw;   br.rdy = 1'b1;
      s = '{bh, IDLE, bw, bw, br, IDLE};
      ev = '{ex(0, 0, 1, 0, 1, 0, 2'd0), ex(0, 0, 0, 0, 0, 0, 2'd0), ex(1, 1, 0, 1, 0, 0, 2'd0),
             ex(1, 1, 0, 1, 0, 0, 2'd2), ex(0, 0, 1, 0, 1, 0, 2'd2), ex(0, 0, 0, 0, 0, 0, 2'd0)};
      foreach (s[i]) begin
         drive(s[i]);
         sb_q.push_back(ev[i]);
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if (obs_a !== e) begin failures++; $display("FAIL branch cyc%0d got=%b exp=%b", i, obs_a, e); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      stim_t w;
      logic [7:0] e;
      do_reset();
      w = IDLE; w.req = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(w);
         sb_q.push_back(ex(1, 1, 0, 1, 0, (i >= 8) ? 1'b1 : 1'b0, (i == 0 || i == 8) ? 2'd0 : 2'd2));
         @(negedge clk);
         e = sb_q.pop_front();
         checks++;
         if (obs_b !== e) begin failures++; $display("FAIL timeout cyc%0d got=%b exp=%b", i, obs_b, e); end
         @(posedge clk); #1;
      end
      rst = 1'b1;
      sb_q.push_back(8'h00);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs_b !== e || cnt_b !== 4'd0) begin
         failures++; $display("FAIL timeout_rst got=%b/%0d exp=%b/0", obs_b, cnt_b, e);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      drive(IDLE);
      sb_q.push_back(8'h00);
      @(negedge clk);
      e = sb_q.pop_front();
      checks++;
      if (obs_b !== e) begin failures++; $display("FAIL timeout_after_rst got=%b exp=%b", obs_b, e); end
      @(posedge clk); #1;
   endtask

   task automatic test_saturate();
      stim_t w;
      int ea, eb;
      do_reset();
      w = IDLE; w.req = 1'b1;
      for (int i = 0; i <= 20; i++) begin
         drive(i < 20 ? w : IDLE);
         cnt_q.push_back(i);
         cnt_q.push_back(i > 15 ? 15 : i);
         @(negedge clk);
         ea = cnt_q.pop_front();
         eb = cnt_q.pop_front();
         checks++;
         if (cnt_a !== 32'(ea)) begin failures++; $display("FAIL sat_a cyc%0d got=%0d exp=%0d", i, cnt_a, ea); end
         checks++;
         if (cnt_b !== 4'(eb)) begin failures++; $display("FAIL sat_b cyc%0d got=%0d exp=%0d", i, cnt_b, eb); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_hazard();
      test_multi_stall();
      test_stall_override();
      test_mem_wait();
      test_branch();
      test_timeout();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Pipeline sequencer for the scalar core. It decides each cycle whether the front end advances, stalls, or is flushed, so the EX/WB forwarding muxes only see operands they can legally resolve. It covers three cases: load-use hazards (forwarding cannot resolve these), multi-cycle data-memory waits, and taken-branch squashes. It sits beside the forwarding unit and drives the enable/clear inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
REG_W, 4, register-index width; index 0 is the hardwired zero register.
LOAD_STALLS, 1, bubbles inserted per load-use hazard (1..7).
MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before forced release (1..255).
CNT_W, 32, width of the stall performance counter.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
r2_id  in  REG_W  decode-stage source A index
r3_id  in  REG_W  decode-stage source B index
r2_used_id  in  1  source A read by the decode instruction
r3_used_id  in  1  source B read (0 when immediate form)
dest_ex  in  REG_W  EX-stage destination index
ex_wr_en  in  1  EX instruction writes the register file
ex_is_load  in  1  EX instruction is a load
mem_req  in  1  MEM-stage memory access active
mem_ready  in  1  memory completes this cycle
branch_taken_ex  in  1  branch resolved taken in EX
stall_front  out  1  hold PC, IF/ID, ID/EX
stall_back  out  1  hold EX/MEM
bubble_ex  out  1  load NOP into ID/EX
bubble_wb  out  1  load NOP into MEM/WB
flush_if_id  out  1  clear IF/ID
mem_timeout  out  1  sticky error flag
stall_count  out  CNT_W  saturating count of cycles with stall_front=1
state_dbg  out  2  current FSM state

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- While rst=1: every output is 0, state=RUN, the load-stall counter is 0, the timeout counter is 0, mem_timeout=0, stall_count=0.
- Control outputs are Mealy: combinational from the registered state and the current inputs. They take effect in the same cycle with zero latency.
- hazard = ex_is_load & ex_wr_en & (dest_ex!=0) & ((r2_used_id & r2_id==dest_ex) | (r3_used_id & r3_id==dest_ex)).
- memwait = mem_req & ~mem_ready.
- States: RUN=0, LOAD_STALL=1, MEM_WAIT=2.
- RUN, priority order memwait > branch_taken_ex > hazard:
  - memwait: stall_front=1, stall_back=1, bubble_wb=1; next state MEM_WAIT; timeout counter <=1.
  - branch_taken_ex: flush_if_id=1, bubble_ex=1, no stall; stay in RUN. The hazard is ignored because the dependent instruction is squashed.
  - hazard: stall_front=1, bubble_ex=1. If LOAD_STALLS>1, next state LOAD_STALL with load counter <=LOAD_STALLS-1; otherwise stay in RUN.
- LOAD_STALL:
  - stall_front=1, bubble_ex=1; the counter decrements; at 1, go to RUN.
  - memwait in this state overrides: go to MEM_WAIT, and the remaining load stalls are dropped.
- MEM_WAIT:
  - stall_front=1, stall_back=1, bubble_wb=1 while memwait.
  - mem_ready=1 or mem_req=0: outputs take RUN-state values for this cycle; next state RUN.
  - Timeout counter increments each cycle. On reaching MEM_TIMEOUT with memwait still 1: set mem_timeout (sticky until rst), release to RUN. Any memwait in the following cycle re-enters MEM_WAIT.
- A branch held in EX during MEM_WAIT is not flushed until the state returns to RUN. ID/EX is frozen, so the branch persists.
- stall_count increments on every cycle with stall_front=1 and saturates at all-ones.
- Reset asserted mid-stall aborts immediately. The next cycle after rst deasserts is RUN with no stall.

Decomposition:
- Package hazard_pkg holds:
  - the enum hcu_state_t {RUN, LOAD_STALL, MEM_WAIT} (2-bit);
  - localparam REG_ZERO = 0;
  - a function src_match(idx, used, dest) used by the hazard equation.
- One natural sub-module, sat_counter (width parameter, enable, synchronous clear). It is instantiated for stall_count and reused for the timeout counter.

Test Plan:
- Load-use: dest_ex=5, ex_is_load=1, ex_wr_en=1, r3_id=5, r3_used_id=1, LOAD_STALLS=1 -> one cycle of stall_front=1, bubble_ex=1; stall_count=1.
- Immediate form: same as above but r3_used_id=0 and r2_id=3 -> no stall. Separately, dest_ex=0 with r2_id=0 -> no stall.
- LOAD_STALLS=3 with hazard -> stall_front=1 for exactly 3 cycles, state_dbg sequence 0,1,1,0.
- mem_req=1, mem_ready=0 for 4 cycles then 1 -> stall_front/stall_back/bubble_wb =1 for 4 cycles, released on the ready cycle.
- Branch and hazard in the same cycle -> flush_if_id=1, bubble_ex=1, stall_front=0. Branch during MEM_WAIT -> flush happens on the first RUN cycle.
- MEM_TIMEOUT=8, mem_ready held 0 -> mem_timeout rises after 8 wait cycles and stays 1 until rst=1; rst pulse mid-wait clears all outputs on the next edge.
